neuron_recall: RTL and testbench
================================

# neuron_recall

Recall-side update unit for the Hopfield/Boltzmann network. The learner writes 9-bit sign-magnitude weights into the weight memory; this block reads them back. On `start` it computes the local field of neuron `i` by serially fetching row `i` of the weight memory and summing the weights of all active neurons `j != i`. It then thresholds the field to produce that neuron's new state. A network-level scheduler drives one update per `start`.

## Interface
Parameters:
- `N`, 8: number of neurons; power of two, 2..64.
- `AW`, 6: weight-memory address width; must satisfy 2^AW >= N*N (6 for N=8).
- `FW`, 12: signed field/accumulator width; must satisfy FW >= 9 + clog2(N).

Ports:
- `clk`, in, 1: single clock; everything is registered on the rising edge.
- `rst`, in, 1: synchronous reset, active-high.
- `start`, in, 1: request one update; sampled only while idle.
- `i_idx`, in, clog2(N): index of the neuron to update; captured when `start` is accepted.
- `x`, in, N: current network state (bit j is neuron j, 1 = active); captured when `start` is accepted.
- `w_addr`, out, AW: weight-memory read address, computed as `i*N + j`.
- `w_ren`, out, 1: read enable for the weight memory.
- `w_rdata`, in, 9: read data; bit 8 is the sign (1 = negative), bits 7:0 the magnitude. Valid exactly one cycle after the address/enable.
- `busy`, out, 1: high while an update is in progress.
- `done`, out, 1: one-cycle pulse when `x_new` and `field` are valid.
- `x_new`, out, 1: new state of neuron `i`.
- `field`, out, FW: final two's-complement local field.

## Operation
- The FSM has three states: IDLE, FETCH, DRAIN.
- IDLE:
  - `start` = 1 latches `i_idx` and `x`, clears the accumulator and the counter j, and moves to FETCH.
  - `busy` rises at that edge.
- FETCH (N cycles, j = 0..N-1):
  - Drives `w_ren` = 1 and `w_addr` = i*N + j.
  - After j = N-1 the FSM moves to DRAIN.
- Accumulate path (one stage behind the fetch):
  - A registered valid/j tag accompanies each read.
  - When the tag is valid, `x[j]` = 1 and j != i, the weight is converted to two's complement and added to the accumulator.
  - Conversion: the magnitude is zero-extended to FW bits and negated when sign = 1.
  - Negative zero {1, 0} contributes 0.
  - Inactive neurons and the diagonal (j == i) contribute 0; the diagonal is fetched but ignored.
  - No saturation is needed: FW is sized so overflow is impossible.
- DRAIN (1 cycle): absorbs the last read, then decides:
  - field > 0 -> `x_new` = 1.
  - field < 0 -> `x_new` = 0.
  - field == 0 -> `x_new` = latched `x[i]` (state is held).
  - `field` and `x_new` are registered, `done` pulses, `busy` drops, and the FSM returns to IDLE.
- `x_new` and `field` hold their values until the next `done`.
- `start` while busy is ignored, with no queuing.
- `start` in the cycle `done` is high is accepted, because the FSM is already in IDLE (back-to-back updates).
- Changes to `i_idx` or `x` after acceptance have no effect on the update in progress.

## Timing
- Edge E0 samples `start`.
- `w_addr` for j occupies the cycle after edge E(j), for j = 0..N-1.
- `w_rdata` for j is sampled at edge E(j+2).
- `done`, `x_new` and `field` update at edge E(N+1): the DRAIN edge, which also sums the data for j = N-1.
- Latency from the `start` edge to `done` is N+1 cycles (9 for N=8).
- Throughput is one update per N+1 cycles.
- `busy` is high from E0 to E(N+1), i.e. for N+1 cycles.
- `w_ren` is high for exactly N consecutive cycles.
- Reset values: `busy`=0, `done`=0, `w_ren`=0, `w_addr`=0, `x_new`=0, `field`=0, FSM=IDLE, accumulator=0.
- Reset mid-update aborts immediately:
  - Next cycle: `w_ren`=0, no `done`.
  - Partial sums are discarded, and `x_new`/`field` return to 0.
- `rst` and `start` in the same cycle: reset wins and `start` is dropped.

## Test plan
- **Reset:** hold `rst` for 2 cycles, pulse `start` during reset -> all outputs 0, no `w_ren`, no `done`.
- **Single positive field:** N=8, i=2, x=8'b0000_1010, w[2][1]={0,5}, w[2][3]={1,3}, all other entries 0 -> `w_addr` 16..23, `done` 9 cycles after `start`, `field`=+2, `x_new`=1.
- **Negative field, diagonal and negative zero:** i=0, x=8'hFF, w[0][0]={0,255}, w[0][1]={1,0}, w[0][7]={1,8}, others 0 -> diagonal and -0 ignored, `field`=-8, `x_new`=0.
- **Zero field holds state:** i=5, w[5][4]={0,7}, w[5][6]={1,7}, x=8'b0111_0000 -> `field`=0, `x_new`=1 (x[5]=1); repeat with x[5]=0 -> `x_new`=0.
- **Extremes:** every off-diagonal weight in row 3 = {0,255} with x=8'hFF -> `field`=+1785; every off-diagonal weight = {1,255} -> `field`=-1785; no overflow.
- **Control:**
  - `start` during FETCH is ignored.
  - `start` in the `done` cycle gives a back-to-back second update with the correct result.
  - `rst` asserted at the 4th FETCH cycle -> `busy`=0 and `w_ren`=0 the next cycle, no `done` ever, and a clean update afterwards.

Source files
------------

// File: rtl/neuron_recall.sv
// Recall-side update unit: serially fetches one weight row, sums the
// weights of active neighbours and thresholds the field into a new state.
module neuron_recall #(
   parameter int N  = 8,
   parameter int AW = 6,
   parameter int FW = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [$clog2(N)-1:0]  i_idx,
   input  logic [N-1:0]          x,
   output logic [AW-1:0]         w_addr,
   output logic                  w_ren,
   input  logic [8:0]            w_rdata,
   output logic                  busy,
   output logic                  done,
   output logic                  x_new,
   output logic signed [FW-1:0]  field
);

   localparam int JW = $clog2(N);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [JW-1:0]        r_i;
   logic [JW-1:0]        r_j;
   logic [JW-1:0]        r_tj;
   logic [N-1:0]         r_x;
   logic                 r_tv;
   logic signed [FW-1:0] r_acc;
   logic signed [FW-1:0] r_field;
   logic [AW-1:0]        r_addr;
   logic                 r_ren;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_xnew;

   logic                 w_last;
   logic [JW-1:0]        w_j_inc;
   logic signed [FW-1:0] w_mag;
   logic signed [FW-1:0] w_contrib;
   logic signed [FW-1:0] w_sum;
   logic                 w_xdec;

   assign w_last  = (r_j == JW'(N - 1));
   assign w_j_inc = r_j + 1'b1;
   assign w_mag   = $signed({{(FW-8){1'b0}}, w_rdata[7:0]});

   // Tag travels one cycle behind the address, matching read latency
   always_comb begin
      w_contrib = '0;
      if (r_tv && r_x[r_tj] && (r_tj != r_i)) begin
         w_contrib = w_rdata[8] ? -w_mag : w_mag;
      end
   end

   assign w_sum = r_acc + w_contrib;

   always_comb begin
      w_xdec = r_x[r_i];
      if (w_sum[FW-1]) begin
         w_xdec = 1'b0;
      end else if (w_sum != '0) begin
         w_xdec = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            if (w_last) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_i     <= '0;
         r_j     <= '0;
         r_tj    <= '0;
         r_x     <= '0;
         r_tv    <= 1'b0;
         r_acc   <= '0;
         r_field <= '0;
         r_addr  <= '0;
         r_ren   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_xnew  <= 1'b0;
      end else begin
         r_tv   <= (r_state == S_FETCH);
         r_tj   <= r_j;
         r_done <= (r_state == S_DRAIN);
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_i    <= i_idx;
                  r_x    <= x;
                  r_acc  <= '0;
                  r_j    <= '0;
                  r_busy <= 1'b1;
                  r_ren  <= 1'b1;
                  r_addr <= AW'({i_idx, {JW{1'b0}}});
               end
            end
            S_FETCH: begin
               r_acc <= w_sum;
               if (w_last) begin
                  r_ren <= 1'b0;
               end else begin
                  r_j    <= w_j_inc;
                  r_addr <= AW'({r_i, w_j_inc});
               end
            end
            S_DRAIN: begin
               r_field <= w_sum;
               r_xnew  <= w_xdec;
               r_acc   <= '0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_busy <= 1'b0;
            end
         endcase
      end
   end

   assign w_addr = r_addr;
   assign w_ren  = r_ren;
   assign busy   = r_busy;
   assign done   = r_done;
   assign x_new  = r_xnew;
   assign field  = r_field;

endmodule

// File: tb/tb_neuron_recall.sv
// Scoreboard bench for neuron_recall: models the weight memory and
// checks addresses, latency, busy length, field and new state.
module tb_neuron_recall;

   localparam int N  = 8;
   localparam int AW = 6;
   localparam int FW = 12;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic [2:0]           i_idx;
   logic [N-1:0]         x;
   logic [AW-1:0]        w_addr;
   logic                 w_ren;
   logic [8:0]           w_rdata;
   logic                 busy;
   logic                 done;
   logic                 x_new;
   logic signed [FW-1:0] field;

   always #5 clk = ~clk;

   neuron_recall #(.N(N), .AW(AW), .FW(FW)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .i_idx   (i_idx),
      .x       (x),
      .w_addr  (w_addr),
      .w_ren   (w_ren),
      .w_rdata (w_rdata),
      .busy    (busy),
      .done    (done),
      .x_new   (x_new),
      .field   (field)
   );

   logic [8:0] mem [64];

   // Registered read: data valid one cycle after address; junk otherwise
   always @(posedge clk) begin
      w_rdata <= w_ren ? mem[w_addr] : 9'($urandom);
   end

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag,
                      input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   typedef struct {
      int fld;
      bit xn;
      int dcyc;
   } exp_t;

   exp_t sb[$];
   int   aq[$];
   bit   abort = 1'b0;
   int   bcnt  = 0;

   function automatic exp_t model(input int i, input logic [7:0] xv,
                                  input int c);
      exp_t e;
      int   s;
      s = 0;
      for (int j = 0; j < N; j++) begin
         if (j != i && xv[j]) begin
            int m;
            m = int'(mem[i*N+j][7:0]);
            s += mem[i*N+j][8] ? -m : m;
         end
      end
      e.fld  = s;
      e.xn   = (s > 0) ? 1'b1 : (s < 0) ? 1'b0 : xv[i];
      e.dcyc = c + N + 2;
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (w_ren) begin
         if (aq.size() == 0) chk("spurious_ren", 1, 0);
         else chk("w_addr", w_addr, aq.pop_front());
      end
      if (done) begin
         if (sb.size() == 0) begin
            chk("spurious_done", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("field", field, e.fld);
            chk("x_new", x_new, e.xn);
            chk("latency", cyc, e.dcyc);
         end
      end
      if (busy) begin
         bcnt++;
      end else begin
         if (bcnt != 0 && !abort) chk("busy_len", bcnt, N + 1);
         if (bcnt != 0) abort = 1'b0;
         bcnt = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic launch(input int i, input logic [7:0] xv);
      i_idx = 3'(i);
      x     = xv;
      start = 1'b1;
      sb.push_back(model(i, xv, cyc));
      for (int j = 0; j < N; j++) aq.push_back(i * N + j);
      tick();
      start = 1'b0;
      i_idx = ~i_idx;
      x     = ~xv;
   endtask

   task automatic wait_done();
      for (int k = 0; k < 40 && !done; k++) tick();
      if (!done) chk("done_timeout", 0, 1);
   endtask

   task automatic clear_mem();
      foreach (mem[a]) mem[a] = '0;
   endtask

   initial begin
      clear_mem();
      rst   = 1'b1;
      start = 1'b1;
      i_idx = '0;
      x     = '1;
      repeat (2) begin
         tick();
         chk("rst_outs", {busy, done, w_ren, w_addr, x_new, field}, 0);
      end
      rst   = 1'b0;
      start = 1'b0;
      tick();
      chk("idle_outs", {busy, done, w_ren}, 0);

      mem[2*N+1] = 9'h005;
      mem[2*N+3] = 9'h103;
      launch(2, 8'b0000_1010);
      wait_done();
      tick();
      chk("hold_field", field, 2);
      chk("hold_xnew", x_new, 1);

      clear_mem();
      mem[0] = 9'h0FF;
      mem[1] = 9'h100;
      mem[7] = 9'h108;
      launch(0, 8'hFF);
      wait_done();
      tick();

      clear_mem();
      mem[5*N+4] = 9'h007;
      mem[5*N+6] = 9'h107;
      launch(5, 8'b0111_0000);
      wait_done();
      tick();
      launch(5, 8'b0101_0000);
      wait_done();
      tick();

      for (int j = 0; j < N; j++) mem[3*N+j] = (j == 3) ? 9'h1FF : 9'h0FF;
      launch(3, 8'hFF);
      wait_done();
      tick();
      for (int j = 0; j < N; j++) mem[3*N+j] = (j == 3) ? 9'h0FF : 9'h1FF;
      launch(3, 8'hFF);
      wait_done();
      tick();

      foreach (mem[a]) mem[a] = 9'($urandom);
      launch(6, 8'hC3);
      tick();
      start = 1'b1;
      i_idx = 3'd1;
      x     = 8'h5A;
      tick();
      start = 1'b0;
      wait_done();

      launch(4, 8'hA5);
      wait_done();
      launch(1, 8'h3C);
      wait_done();
      for (int r = 0; r < 6; r++) begin
         launch(int'($urandom_range(0, N - 1)), 8'($urandom));
         wait_done();
      end
      tick();

      launch(3, 8'hFF);
      repeat (3) tick();
      abort = 1'b1;
      rst   = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      aq.delete();
      chk("abort_busy", busy, 0);
      chk("abort_ren", w_ren, 0);
      chk("abort_field", field, 0);
      chk("abort_xnew", x_new, 0);
      repeat (15) tick();
      launch(5, 8'h77);
      wait_done();
      repeat (3) tick();

      chk("sb_empty", sb.size() + aq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
